// File: rtl/decoder_seq.sv
// Multi-cycle MIPS sequencer: FETCH/EXEC/MEM/MULDIV with delay-slot redirect; outputs are pure decode.
// ALU/branch 2 cycles, load/store 3 + mem_wait cycles, mult/div 2+MULDIV_CYCLES; mem_wait holds MEM.
module decoder_seq #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = $clog2(MULDIV_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       zero,
  input  logic       sign,
  input  logic       mem_wait,
  output logic       fetch_req,
  output logic       regwrite,
  output logic       link,
  output logic       data_read,
  output logic       data_write,
  output logic       muldiv_start,
  output logic       hilo_write,
  output logic       target_capture,
  output logic       pc_update,
  output logic       pc_load_target,
  output logic       err
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, MULDIV} state_t;

  typedef struct packed {
    logic alu;
    logic load;
    logic store;
    logic muldiv;
    logic mfhilo;
    logic mthilo;
    logic branch;
    logic jump;
    logic link;
    logic bad;
  } dec_t;

  state_t           state, state_nxt;
  logic             pend, pend_nxt;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  dec_t             dec;
  logic             br_cond;
  logic             taken;

  // Instruction class decode; op/funct/rt are held stable for the whole instruction.
  always_comb begin
    dec     = '0;
    br_cond = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B:               dec.alu = 1'b1;
          6'h08:                                    dec.jump = 1'b1;
          6'h09: begin
            dec.jump = 1'b1;
            dec.link = 1'b1;
          end
          6'h10, 6'h12:                             dec.mfhilo = 1'b1;
          6'h11, 6'h13:                             dec.mthilo = 1'b1;
          6'h18, 6'h19, 6'h1A, 6'h1B:               dec.muldiv = 1'b1;
          default:                                  dec.bad = 1'b1;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00: begin
            dec.branch = 1'b1;
            br_cond    = sign;
          end
          5'h01: begin
            dec.branch = 1'b1;
            br_cond    = !sign;
          end
          5'h10: begin
            dec.branch = 1'b1;
            dec.link   = 1'b1;
            br_cond    = sign;
          end
          5'h11: begin
            dec.branch = 1'b1;
            dec.link   = 1'b1;
            br_cond    = !sign;
          end
          default: dec.bad = 1'b1;
        endcase
      end
      6'h02: dec.jump = 1'b1;
      6'h03: begin
        dec.jump = 1'b1;
        dec.link = 1'b1;
      end
      6'h04: begin
        dec.branch = 1'b1;
        br_cond    = zero;
      end
      6'h05: begin
        dec.branch = 1'b1;
        br_cond    = !zero;
      end
      6'h06: begin
        dec.branch = 1'b1;
        br_cond    = sign | zero;
      end
      6'h07: begin
        dec.branch = 1'b1;
        br_cond    = !sign & !zero;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:    dec.alu = 1'b1;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: dec.load = 1'b1;
      6'h28, 6'h29, 6'h2B:           dec.store = 1'b1;
      default:                       dec.bad = 1'b1;
    endcase
  end

  assign taken = dec.jump | (dec.branch & br_cond);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend  <= 1'b0;
      err_q <= 1'b0;
      count <= '0;
    end else begin
      pend  <= pend_nxt;
      err_q <= err_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    err_nxt   = err_q;
    case (state)
      FETCH: if (instr_valid) state_nxt = EXEC;
      EXEC: begin
        if (dec.load | dec.store) begin
          state_nxt = MEM;
        end else if (dec.muldiv) begin
          state_nxt = MULDIV;
          count_nxt = CNT_W'(MULDIV_CYCLES - 1);
        end else begin
          state_nxt = FETCH;
        end
        if (dec.bad) err_nxt = 1'b1;
      end
      MEM: if (!mem_wait) state_nxt = FETCH;
      MULDIV: begin
        if (count == '0) state_nxt = FETCH;
        else             count_nxt = count - 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
    // A taken branch in a delay slot re-arms pend on the same edge that consumes it.
    if (target_capture)  pend_nxt = 1'b1;
    else if (pc_update)  pend_nxt = 1'b0;
    else                 pend_nxt = pend;
  end

  always_comb begin
    fetch_req      = 1'b0;
    regwrite       = 1'b0;
    link           = 1'b0;
    data_read      = 1'b0;
    data_write     = 1'b0;
    muldiv_start   = 1'b0;
    hilo_write     = 1'b0;
    target_capture = 1'b0;
    pc_update      = 1'b0;
    case (state)
      FETCH: fetch_req = 1'b1;
      EXEC: begin
        if (dec.muldiv) begin
          muldiv_start = 1'b1;
        end else if (!(dec.load | dec.store)) begin
          pc_update      = 1'b1;
          regwrite       = dec.alu | dec.mfhilo | dec.link;
          link           = dec.link;
          hilo_write     = dec.mthilo;
          target_capture = taken;
        end
      end
      MEM: begin
        data_read  = dec.load;
        data_write = dec.store;
        if (!mem_wait) begin
          regwrite  = dec.load;
          pc_update = 1'b1;
        end
      end
      MULDIV: begin
        if (count == '0) begin
          hilo_write = 1'b1;
          pc_update  = 1'b1;
        end
      end
      default: ;
    endcase
    pc_load_target = pc_update & pend;
    err            = err_q;
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq (MULDIV_CYCLES=4): per-cycle output vector compared against hand-built masks.
module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [5:0] op, funct;
  logic [4:0] rt;
  logic       zero, sign, mem_wait;
  logic       fetch_req, regwrite, link, data_read, data_write, muldiv_start;
  logic       hilo_write, target_capture, pc_update, pc_load_target, err;

  decoder_seq #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .op(op), .funct(funct), .rt(rt),
    .zero(zero), .sign(sign), .mem_wait(mem_wait), .fetch_req(fetch_req), .regwrite(regwrite),
    .link(link), .data_read(data_read), .data_write(data_write), .muldiv_start(muldiv_start),
    .hilo_write(hilo_write), .target_capture(target_capture), .pc_update(pc_update),
    .pc_load_target(pc_load_target), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] F  = 11'h400, RW = 11'h200, LK = 11'h100, DR = 11'h080,
                          DW = 11'h040, MS = 11'h020, HW = 11'h010, TC = 11'h008,
                          PU = 11'h004, PL = 11'h002, ER = 11'h001;

  wire [10:0] outv = {fetch_req, regwrite, link, data_read, data_write, muldiv_start,
                      hilo_write, target_capture, pc_update, pc_load_target, err};

  int checks = 0;
  int failures = 0;
  logic [10:0] err_exp = '0;
  logic [5:0]  n_op = '0, n_fn = '0;
  logic [4:0]  n_rt = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ins(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    n_op = o;
    n_fn = f;
    n_rt = r;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step(input logic v, input logic z, input logic s, input logic mw,
                      input string tag, input logic [10:0] exp);
    @(negedge clk);
    op = n_op; funct = n_fn; rt = n_rt;
    instr_valid = v; zero = z; sign = s; mem_wait = mw;
    #1;
    chk(tag, 32'(outv), 32'(exp | err_exp));
  endtask

  task automatic run2(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                      input logic z, input logic s, input string tag, input logic [10:0] exp);
    ins(o, f, r);
    step(1'b1, 1'b0, 1'b0, 1'b0, {tag, "_f"}, F);
    step(1'b0, z, s, 1'b0, {tag, "_x"}, exp);
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; op = '0; funct = '0; rt = '0;
    zero = 1'b0; sign = 1'b0; mem_wait = 1'b0;
    @(negedge clk); #1;
    chk("rst_hold", 32'(outv), 32'(F));
    @(negedge clk);
    reset = 1'b0;

    run2(6'h00, 6'h21, 5'h0, 0, 0, "addu", RW | PU);
    step(0, 0, 0, 0, "addu_next", F);

    run2(6'h04, 6'h00, 5'h0, 1, 0, "beq_t", TC | PU);
    run2(6'h00, 6'h21, 5'h0, 0, 0, "slot", RW | PU | PL);
    run2(6'h00, 6'h21, 5'h0, 0, 0, "post_slot", RW | PU);
    run2(6'h04, 6'h00, 5'h0, 0, 0, "beq_nt", PU);
    run2(6'h00, 6'h21, 5'h0, 0, 0, "beq_nt_next", RW | PU);

    ins(6'h23, 6'h00, 5'h0);
    step(1, 0, 0, 0, "lw_f", F);
    step(0, 0, 0, 1, "lw_x", '0);
    step(0, 0, 0, 1, "lw_m1", DR);
    step(0, 0, 0, 1, "lw_m2", DR);
    step(0, 0, 0, 1, "lw_m3", DR);
    step(0, 0, 0, 0, "lw_m4", DR | RW | PU);

    ins(6'h2B, 6'h00, 5'h0);
    step(1, 0, 0, 0, "sw_f", F);
    step(0, 0, 0, 0, "sw_x", '0);
    step(0, 0, 0, 0, "sw_m", DW | PU);

    ins(6'h00, 6'h18, 5'h0);
    step(1, 0, 0, 0, "mult_f", F);
    step(0, 0, 0, 0, "mult_x", MS);
    step(0, 0, 0, 0, "mult_c3", '0);
    step(0, 0, 0, 0, "mult_c2", '0);
    step(0, 0, 0, 0, "mult_c1", '0);
    step(0, 0, 0, 0, "mult_c0", HW | PU);
    step(0, 0, 0, 0, "mult_next", F);

    run2(6'h01, 6'h00, 5'h11, 0, 1, "bgezal_nt", RW | LK | PU);
    run2(6'h00, 6'h09, 5'h0, 0, 0, "jalr", RW | LK | TC | PU);
    run2(6'h0D, 6'h00, 5'h0, 0, 0, "ori_slot", RW | PU | PL);
    run2(6'h02, 6'h00, 5'h0, 0, 0, "j", TC | PU);
    run2(6'h04, 6'h00, 5'h0, 1, 0, "beq_in_slot", TC | PU | PL);
    run2(6'h0F, 6'h00, 5'h0, 0, 0, "lui_slot2", RW | PU | PL);
    run2(6'h0F, 6'h00, 5'h0, 0, 0, "lui_clean", RW | PU);
    run2(6'h07, 6'h00, 5'h0, 1, 0, "bgtz_zero", PU);
    run2(6'h06, 6'h00, 5'h0, 0, 1, "blez_neg", TC | PU);
    run2(6'h00, 6'h12, 5'h0, 0, 0, "mflo_slot", RW | PU | PL);
    run2(6'h00, 6'h11, 5'h0, 0, 0, "mthi", HW | PU);
    run2(6'h01, 6'h00, 5'h00, 0, 0, "bltz_pos", PU);

    run2(6'h3F, 6'h00, 5'h0, 0, 0, "bad", PU);
    err_exp = ER;
    ins(6'h00, 6'h1A, 5'h0);
    step(1, 0, 0, 0, "div_f", F);
    step(0, 0, 0, 0, "div_x", MS);
    step(0, 0, 0, 0, "div_c3", '0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    err_exp = '0;
    chk("rst_mid_muldiv", 32'(outv), 32'(F));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "idle_after_rst", F);

    run2(6'h00, 6'h21, 5'h0, 0, 0, "addu_after_rst", RW | PU);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
